// File: rtl/dma_pkg.sv
// Shared definitions for the DMA multi-channel controller.
//   state_e : controller FSM states
//   WeRead / WeWrite : dma_we codes driven towards memory
package dma_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StXfer,
        StDone,
        StErr
    } state_e;

    localparam logic [1:0] WeRead  = 2'b00;
    localparam logic [1:0] WeWrite = 2'b11;

endpackage

// File: rtl/dma_fifo.sv
// Synchronous FIFO of 2^FIFO_DEPTH words used as the staging buffer between memory and device.
// Ports:
//   clk, reset   : clock, synchronous active-low reset
//   flush        : drop all stored words
//   push, din    : write request and data (ignored when full unless popping in the same cycle)
//   pop, dout    : read request (ignored when empty), head word
//   full, empty  : status flags
//   level        : number of stored words (0 .. 2^FIFO_DEPTH)
module dma_fifo #(
    parameter int unsigned DATA_LEN   = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                push,
    input  logic                pop,
    input  logic [DATA_LEN-1:0] din,
    output logic [DATA_LEN-1:0] dout,
    output logic                full,
    output logic                empty,
    output logic [FIFO_DEPTH:0] level
);

    localparam int unsigned Words = 1 << FIFO_DEPTH;

    logic [DATA_LEN-1:0] mem [Words];
    // The extra MSB on each pointer tells a full FIFO apart from an empty one.
    logic [FIFO_DEPTH:0] wr_ptr_q;
    logic [FIFO_DEPTH:0] rd_ptr_q;
    logic                do_push;
    logic                do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[FIFO_DEPTH] != rd_ptr_q[FIFO_DEPTH]) &&
                     (wr_ptr_q[FIFO_DEPTH-1:0] == rd_ptr_q[FIFO_DEPTH-1:0]);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push into a full FIFO is allowed then.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_q[FIFO_DEPTH-1:0]];

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[FIFO_DEPTH-1:0]] <= din;
    end

endmodule

// File: rtl/dma_mc_controller.sv
// Multi-channel DMA controller: round-robin arbitration between NUM_CH device channels, one job
// at a time, staging words through a FIFO between the memory port and the device port.
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   rqst/rd_wr/addr_fix        : per-channel job request, direction (1 = mem->dev), fixed address
//   dev_addr/num_words         : per-channel start address and word count (packed per channel)
//   dev_ack/dev_in             : device strobe and write data
//   dma_ack/dev_out            : controller strobe and read data towards the device
//   end_flag/err_flag/busy     : per-channel done/error pulses, job active
//   dma_in/dma_ready/dma_resp  : memory read data, access accepted, access error
//   dma_addr/dma_out/dma_en/dma_we/dma_priority : memory request
module dma_mc_controller
    import dma_pkg::*;
#(
    parameter int unsigned ADD_LEN         = 16,
    parameter int unsigned DATA_LEN        = 16,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned FIFO_DIV_FACTOR = 2,
    parameter int unsigned NUM_CH          = 2,
    parameter int unsigned CNT_LEN         = FIFO_DEPTH + 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_CH-1:0]         rqst,
    input  logic [NUM_CH-1:0]         rd_wr,
    input  logic [NUM_CH-1:0]         addr_fix,
    input  logic [NUM_CH*ADD_LEN-1:0] dev_addr,
    input  logic [NUM_CH*CNT_LEN-1:0] num_words,
    input  logic [NUM_CH-1:0]         dev_ack,
    input  logic [DATA_LEN-1:0]       dev_in,
    output logic [NUM_CH-1:0]         dma_ack,
    output logic [DATA_LEN-1:0]       dev_out,
    output logic [NUM_CH-1:0]         end_flag,
    output logic [NUM_CH-1:0]         err_flag,
    output logic                      busy,
    input  logic [DATA_LEN-1:0]       dma_in,
    input  logic                      dma_ready,
    input  logic                      dma_resp,
    output logic [ADD_LEN-1:0]        dma_addr,
    output logic [DATA_LEN-1:0]       dma_out,
    output logic                      dma_en,
    output logic [1:0]                dma_we,
    output logic                      dma_priority
);

    localparam int unsigned ChW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned LvlW  = FIFO_DEPTH + 1;
    localparam int unsigned Words = 1 << FIFO_DEPTH;
    localparam logic [FIFO_DEPTH:0] LvlFull = LvlW'(Words);
    localparam logic [FIFO_DEPTH:0] LvlThr  = LvlW'(Words >> FIFO_DIV_FACTOR);

    state_e               state_q, state_d;
    logic [ChW-1:0]       ch_q, rr_q, sel, rr_next;
    logic                 rd_wr_q, fix_q;
    logic [ADD_LEN-1:0]   addr_q;
    logic [CNT_LEN-1:0]   cnt_q, issued_q, dev_cnt_q;
    logic                 accept, dev_hs, ack_bit;
    logic                 fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [DATA_LEN-1:0]  fifo_din, fifo_dout;
    logic [FIFO_DEPTH:0]  fifo_level;

    dma_fifo #(
        .DATA_LEN   (DATA_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (fifo_flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Round-robin pick: scan from rr_q upward; walking backwards lets the first hit win.
    always_comb begin
        int idx;
        sel = rr_q;
        idx = 0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            idx = int'(rr_q) + i;
            if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
            if (rqst[idx]) sel = ChW'(idx);
        end
        rr_next = (ch_q == ChW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        dma_en       = 1'b0;
        dma_we       = WeRead;
        dma_out      = '0;
        dma_ack      = '0;
        dev_out      = '0;
        end_flag     = '0;
        err_flag     = '0;
        busy         = (state_q != StIdle);
        dma_priority = 1'b0;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        fifo_flush   = 1'b0;
        fifo_din     = rd_wr_q ? dma_in : dev_in;
        ack_bit      = 1'b0;
        accept       = 1'b0;
        dev_hs       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|rqst) state_d = StGrant;
            end
            StGrant: begin
                state_d = (num_words[ch_q*CNT_LEN +: CNT_LEN] == '0) ? StDone : StXfer;
            end
            StXfer: begin
                if (rd_wr_q) begin
                    // Empty slot needed before issuing, so the accepted word always fits.
                    dma_en       = (issued_q < cnt_q) && (fifo_level < LvlFull);
                    accept       = dma_en && dma_ready;
                    ack_bit      = !fifo_empty;
                    dev_out      = fifo_empty ? '0 : fifo_dout;
                    dev_hs       = ack_bit && dev_ack[ch_q];
                    fifo_push    = accept && !dma_resp;
                    fifo_pop     = dev_hs;
                    dma_priority = (fifo_level <= LvlThr);
                    if (dev_cnt_q == cnt_q) state_d = StDone;
                end else begin
                    dma_en       = !fifo_empty;
                    dma_we       = dma_en ? WeWrite : WeRead;
                    dma_out      = dma_en ? fifo_dout : '0;
                    accept       = dma_en && dma_ready;
                    ack_bit      = !fifo_full && (dev_cnt_q < cnt_q);
                    dev_hs       = ack_bit && dev_ack[ch_q];
                    fifo_push    = dev_hs;
                    fifo_pop     = accept && !dma_resp;
                    dma_priority = (fifo_level >= LvlFull - LvlThr);
                    if (issued_q == cnt_q) state_d = StDone;
                end
                dma_ack[ch_q] = ack_bit;
                if (accept && dma_resp) state_d = StErr;
            end
            StDone: begin
                end_flag[ch_q] = 1'b1;
                state_d        = StIdle;
            end
            StErr: begin
                err_flag[ch_q] = 1'b1;
                fifo_flush     = 1'b1;
                state_d        = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign dma_addr = addr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            ch_q      <= '0;
            rr_q      <= '0;
            rd_wr_q   <= 1'b0;
            fix_q     <= 1'b0;
            addr_q    <= '0;
            cnt_q     <= '0;
            issued_q  <= '0;
            dev_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && |rqst) ch_q <= sel;
            if (state_q == StGrant) begin
                rd_wr_q   <= rd_wr[ch_q];
                fix_q     <= addr_fix[ch_q];
                addr_q    <= dev_addr[ch_q*ADD_LEN +: ADD_LEN];
                cnt_q     <= num_words[ch_q*CNT_LEN +: CNT_LEN];
                issued_q  <= '0;
                dev_cnt_q <= '0;
            end
            if (accept) begin
                issued_q <= issued_q + 1'b1;
                if (!fix_q) addr_q <= addr_q + 1'b1;
            end
            if (dev_hs) dev_cnt_q <= dev_cnt_q + 1'b1;
            // An errored job also counts as served so a faulty channel cannot starve others.
            if (state_q == StDone || state_q == StErr) rr_q <= rr_next;
        end
    end

endmodule

// File: tb/tb_dma_mc_controller.sv
// Directed self-checking bench for dma_mc_controller with a memory/device model and scoreboard.
module tb_dma_mc_controller;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int FD = 4;
    localparam int NC = 2;
    localparam int CL = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NC-1:0] rqst = '0, rd_wr = '0, addr_fix = '0, dev_ack = '0;
    logic [NC*AW-1:0] dev_addr = '0;
    logic [NC*CL-1:0] num_words = '0;
    logic [DW-1:0] dev_in = '0, dma_in = '0;
    logic          dma_ready = 1'b0, dma_resp = 1'b0;
    logic [NC-1:0] dma_ack, end_flag, err_flag;
    logic [DW-1:0] dev_out, dma_out;
    logic [AW-1:0] dma_addr;
    logic          busy, dma_en, dma_priority;
    logic [1:0]    dma_we;

    always #5 clk = ~clk;

    dma_mc_controller #(
        .ADD_LEN         (AW),
        .DATA_LEN        (DW),
        .FIFO_DEPTH      (FD),
        .FIFO_DIV_FACTOR (2),
        .NUM_CH          (NC),
        .CNT_LEN         (CL)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rqst         (rqst),
        .rd_wr        (rd_wr),
        .addr_fix     (addr_fix),
        .dev_addr     (dev_addr),
        .num_words    (num_words),
        .dev_ack      (dev_ack),
        .dev_in       (dev_in),
        .dma_ack      (dma_ack),
        .dev_out      (dev_out),
        .end_flag     (end_flag),
        .err_flag     (err_flag),
        .busy         (busy),
        .dma_in       (dma_in),
        .dma_ready    (dma_ready),
        .dma_resp     (dma_resp),
        .dma_addr     (dma_addr),
        .dma_out      (dma_out),
        .dma_en       (dma_en),
        .dma_we       (dma_we),
        .dma_priority (dma_priority)
    );

    wire [58:0] all_out = {dma_ack, dev_out, end_flag, err_flag, busy, dma_addr, dma_out,
                           dma_en, dma_we, dma_priority};

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_rdata[$];
    logic [DW-1:0] exp_wdata[$];
    int            end_order[$];
    logic [NC-1:0] rd_cfg = '0;
    logic [DW-1:0] wseq = 16'h0100;
    int  cyc_n = 0, ready_from = 0, resp_at = -1, acc_cnt = 0, dev_words = 0;
    int  end_total = 0, end_target = 0, err_total = 0;
    bit  auto_drop = 1'b1, en_seen = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // One clock: advance past posedge, then act as memory and device at the negedge.
    task automatic cyc();
        logic [DW-1:0] e;
        @(posedge clk);
        @(negedge clk);
        cyc_n++;
        dma_ready = (cyc_n >= ready_from);
        dma_resp  = 1'b0;
        dma_in    = '0;
        dev_ack   = '0;
        if (dma_en) begin
            en_seen = 1'b1;
            dma_in  = mem_f(dma_addr);
            if (dma_ready) begin
                if (acc_cnt == resp_at) dma_resp = 1'b1;
                acc_cnt++;
                check("addr_expected", 64'(exp_addr.size() > 0), 64'(1));
                if (exp_addr.size() > 0) check("dma_addr", 64'(dma_addr), 64'(exp_addr.pop_front()));
                if (dma_we == 2'b11) begin
                    check("wdata_expected", 64'(exp_wdata.size() > 0), 64'(1));
                    if (exp_wdata.size() > 0) begin
                        e = exp_wdata.pop_front();
                        check("dma_out", 64'(dma_out), 64'(e));
                    end
                end else begin
                    check("dma_we_read", 64'(dma_we), 64'(0));
                end
            end
        end
        check("ack_onehot", 64'($countones(dma_ack) <= 1), 64'(1));
        for (int c = 0; c < NC; c++) begin
            if (dma_ack[c]) begin
                dev_ack[c] = 1'b1;
                dev_words++;
                if (rd_cfg[c]) begin
                    check("rdata_expected", 64'(exp_rdata.size() > 0), 64'(1));
                    if (exp_rdata.size() > 0) begin
                        e = exp_rdata.pop_front();
                        check("dev_out", 64'(dev_out), 64'(e));
                    end
                end else begin
                    dev_in = wseq;
                    exp_wdata.push_back(wseq);
                    wseq++;
                end
            end
            if (end_flag[c]) begin
                end_total++;
                end_order.push_back(c);
            end
        end
        err_total += $countones(err_flag);
        if (auto_drop && busy) rqst = '0;
        if (end_target != 0 && end_total >= end_target) rqst = '0;
    endtask

    task automatic plan_job(input int c, input bit rd, input bit fix, input logic [AW-1:0] a,
                            input int n);
        logic [AW-1:0] aa;
        rd_cfg[c]   = rd;
        rd_wr[c]    = rd;
        addr_fix[c] = fix;
        dev_addr[c*AW +: AW]  = a;
        num_words[c*CL +: CL] = CL'(n);
        for (int i = 0; i < n; i++) begin
            aa = fix ? a : a + AW'(i);
            exp_addr.push_back(aa);
            if (rd) exp_rdata.push_back(mem_f(aa));
        end
    endtask

    task automatic wait_flag(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            cyc();
            if (end_flag != '0 || err_flag != '0) return;
        end
        checks++;
        errors++;
        $error("FAIL %s_timeout: observed no flag expected a flag within %0d cycles", tag, limit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0, w0, e0, r0;
        repeat (3) cyc();
        check("reset_outputs", 64'(all_out), 64'(0));
        reset = 1'b1;
        cyc();
        check("idle_busy", 64'(busy), 64'(0));

        // Channel 0 read of three words from 0x0010.
        a0 = acc_cnt;
        plan_job(0, 1'b1, 1'b0, 16'h0010, 3);
        rqst = 2'b01;
        wait_flag("t1", 40);
        check("t1_end_flag", 64'(end_flag), 64'(2'b01));
        check("t1_busy_done", 64'(busy), 64'(1));
        cyc();
        check("t1_end_pulse", 64'(end_flag), 64'(0));
        check("t1_busy_after", 64'(busy), 64'(0));
        check("t1_accesses", 64'(acc_cnt - a0), 64'(3));
        check("t1_rdata_left", 64'(exp_rdata.size()), 64'(0));

        // Channel 1 write of 20 words while memory stalls for 30 cycles.
        a0 = acc_cnt;
        w0 = dev_words;
        plan_job(1, 1'b0, 1'b0, 16'h0040, 20);
        ready_from = cyc_n + 30;
        rqst = 2'b10;
        repeat (29) cyc();
        check("t2_words_at_full", 64'(dev_words - w0), 64'(16));
        check("t2_ack_dropped", 64'(dma_ack), 64'(0));
        check("t2_priority", 64'(dma_priority), 64'(1));
        check("t2_en_stalled", 64'(dma_en), 64'(1));
        wait_flag("t2", 100);
        check("t2_end_flag", 64'(end_flag), 64'(2'b10));
        check("t2_words", 64'(dev_words - w0), 64'(20));
        check("t2_accesses", 64'(acc_cnt - a0), 64'(20));
        check("t2_wdata_left", 64'(exp_wdata.size()), 64'(0));
        cyc();

        // Both channels request continuously from reset: grants alternate 0,1,0,1.
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        e0 = end_total;
        end_order.delete();
        plan_job(0, 1'b1, 1'b0, 16'h0100, 2);
        plan_job(1, 1'b0, 1'b0, 16'h0200, 2);
        plan_job(0, 1'b1, 1'b0, 16'h0100, 2);
        plan_job(1, 1'b0, 1'b0, 16'h0200, 2);
        auto_drop  = 1'b0;
        end_target = e0 + 4;
        rqst = 2'b11;
        for (int i = 0; i < 200 && end_total < end_target; i++) cyc();
        check("t3_jobs", 64'(end_total - e0), 64'(4));
        for (int i = 0; i < 4 && i < end_order.size(); i++)
            check("t3_grant_order", 64'(end_order[i]), 64'(i % 2));
        auto_drop  = 1'b1;
        end_target = 0;
        cyc();
        check("t3_addr_left", 64'(exp_addr.size()), 64'(0));

        // Fixed-address write of four words to 0x0300.
        a0 = acc_cnt;
        plan_job(0, 1'b0, 1'b1, 16'h0300, 4);
        rqst = 2'b01;
        wait_flag("t4", 60);
        check("t4_end_flag", 64'(end_flag), 64'(2'b01));
        check("t4_accesses", 64'(acc_cnt - a0), 64'(4));
        check("t4_addr_left", 64'(exp_addr.size()), 64'(0));
        cyc();

        // Zero-length job: end_flag two cycles after the request, no memory traffic.
        plan_job(1, 1'b1, 1'b0, 16'h0400, 0);
        en_seen = 1'b0;
        rqst = 2'b10;
        cyc();
        check("t5_end_c1", 64'(end_flag), 64'(0));
        cyc();
        check("t5_end_c2", 64'(end_flag), 64'(2'b10));
        cyc();
        check("t5_no_en", 64'(en_seen), 64'(0));
        check("t5_busy", 64'(busy), 64'(0));

        // Memory error on the second access of a read job.
        e0 = end_total;
        r0 = err_total;
        plan_job(0, 1'b1, 1'b0, 16'h0500, 4);
        resp_at = acc_cnt + 1;
        rqst = 2'b01;
        wait_flag("t6", 40);
        check("t6_err_flag", 64'(err_flag), 64'(2'b01));
        check("t6_no_end", 64'(end_flag), 64'(0));
        cyc();
        check("t6_busy_after", 64'(busy), 64'(0));
        check("t6_err_pulses", 64'(err_total - r0), 64'(1));
        check("t6_end_count", 64'(end_total - e0), 64'(0));
        resp_at = -1;
        exp_addr.delete();
        exp_rdata.delete();

        // Reset asserted mid-transfer aborts silently.
        plan_job(1, 1'b1, 1'b0, 16'h0600, 10);
        ready_from = cyc_n + 1000;
        rqst = 2'b10;
        repeat (5) cyc();
        check("t7_busy_xfer", 64'(busy), 64'(1));
        reset = 1'b0;
        cyc();
        check("t7_reset_outputs", 64'(all_out), 64'(0));
        reset = 1'b1;
        en_seen = 1'b0;
        e0 = end_total;
        r0 = err_total;
        ready_from = 0;
        repeat (10) cyc();
        check("t7_no_en", 64'(en_seen), 64'(0));
        check("t7_no_end", 64'(end_total - e0), 64'(0));
        check("t7_no_err", 64'(err_total - r0), 64'(0));
        check("t7_idle", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
